// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide sequencer for the execute stage.
// Two-cycle registered multiply, 32-step restoring divide, flush-cancelable.
module mdu_seq #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic        mulOrdivE,
  input  logic        mdIsSignE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        cancel,
  output logic        stall_md,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = $clog2(DIV_ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic            sgn_q;
  logic [31:0]     dvs_q;
  logic [63:0]     rq_q;
  logic            qneg_q;
  logic            rneg_q;
  logic            dz_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic            rv_q;

  logic [31:0]     a_abs;
  logic [31:0]     b_abs;
  logic [63:0]     mul_a;
  logic [63:0]     mul_b;
  logic [63:0]     prod;
  logic [32:0]     rem33;
  logic            ge;
  logic [31:0]     diff;
  logic [63:0]     rq_d;
  logic [31:0]     quo_fix;
  logic [31:0]     rem_fix;

  // Operand magnitudes, product and one restoring-divide step.
  always_comb begin
    a_abs   = (mdIsSignE && srcaE[31]) ? (32'd0 - srcaE) : srcaE;
    b_abs   = (mdIsSignE && srcbE[31]) ? (32'd0 - srcbE) : srcbE;
    mul_a   = {{32{sgn_q & a_q[31]}}, a_q};
    mul_b   = {{32{sgn_q & b_q[31]}}, b_q};
    prod    = mul_a * mul_b;
    rem33   = rq_q[63:31];
    ge      = rem33 >= {1'b0, dvs_q};
    diff    = rem33[31:0] - dvs_q;
    rq_d    = ge ? {diff, rq_q[30:0], 1'b1}
                 : {rq_q[62:0], 1'b0};
    quo_fix = qneg_q ? (32'd0 - rq_q[31:0]) : rq_q[31:0];
    rem_fix = rneg_q ? (32'd0 - rq_q[63:32]) : rq_q[63:32];
  end

  // Sequencer FSM with registered result and valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dvs_q   <= '0;
      rq_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      rv_q    <= 1'b0;
    end else if (cancel) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          rv_q <= 1'b0;
          if (startE) begin
            a_q     <= srcaE;
            b_q     <= srcbE;
            sgn_q   <= mdIsSignE;
            dvs_q   <= b_abs;
            rq_q    <= {32'd0, a_abs};
            qneg_q  <= mdIsSignE & (srcaE[31] ^ srcbE[31]);
            rneg_q  <= mdIsSignE & srcaE[31];
            dz_q    <= (srcbE == 32'd0);
            cnt_q   <= '0;
            state_q <= mulOrdivE ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          hi_q    <= prod[63:32];
          lo_q    <= prod[31:0];
          rv_q    <= 1'b1;
          state_q <= S_DONE;
        end
        S_DIV: begin
          rq_q <= rq_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIX: begin
          // Divide by zero: dividend to hi, all-ones to lo, no sign fix.
          hi_q    <= dz_q ? a_q : rem_fix;
          lo_q    <= dz_q ? 32'hFFFF_FFFF : quo_fix;
          rv_q    <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          rv_q    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          rv_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall asserts in the accept cycle itself and drops at once on reset.
  always_comb begin
    busy      = (state_q != S_IDLE);
    stall_md  = rst & (((state_q == S_IDLE) & startE & ~cancel)
                     | (state_q == S_MUL)
                     | (state_q == S_DIV)
                     | (state_q == S_FIX));
    res_valid = rv_q;
    hi_o      = hi_q;
    lo_o      = lo_q;
  end

endmodule
